// File: rtl/uart_reg_ctrl.sv
// ---------------------------------------------------------------------------
// uart_reg_ctrl
//   Byte-oriented register-file controller driven by a UART receiver.
//   Frames, one byte per rx_done strobe:
//     write : 'W' (0x57), addr, data  -> response 'K' (0x4B)
//     read  : 'R' (0x52), addr        -> response reg[addr]
//   A bad command byte or an out-of-range address answers '?' (0x3F) and
//   pulses err. Exactly one response byte per accepted or rejected frame is
//   handed to the transmitter with a one-cycle tx_start once tx_busy is low.
//
//   Optional feature macro: CMD_TIMEOUT_EN
//     When defined, a partially received frame is abandoned (err pulse, no
//     response) after TIMEOUT_CYCLES-1 cycles without a new byte. When not
//     defined, the controller waits indefinitely for the next frame byte.
//
// Parameters
//   NUM_REGS       number of 8-bit registers (power of 2, 2..256)
//   TIMEOUT_CYCLES inter-byte timeout in clk cycles (CMD_TIMEOUT_EN only)
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   rx_data   in   received byte, valid with rx_done
//   rx_done   in   one-cycle strobe for rx_data
//   tx_busy   in   transmitter busy
//   tx_data   out  response byte (changes only on entry to the response state)
//   tx_start  out  one-cycle strobe: send tx_data
//   reg0_out  out  registered copy of register 0
//   err       out  one-cycle strobe on a rejected or abandoned frame
// ---------------------------------------------------------------------------
module uart_reg_ctrl #(
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [7:0] reg0_out,
  output logic       err
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_BAD   = 8'h3F;

  // Elaboration-time parameter sanity checks.
  if ((NUM_REGS < 2) || (NUM_REGS > 256) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_num_regs
    $error("uart_reg_ctrl: NUM_REGS must be a power of 2 in 2..256");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_reg_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    GET_DATA = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      regs [NUM_REGS];
  logic            is_write;
  logic            is_write_next;
  logic [AW-1:0]   addr;
  logic [AW-1:0]   addr_next;
  logic [7:0]      tx_data_next;
  logic            tx_start_next;
  logic            err_next;
  logic            wr_en;
  logic            addr_ok;
  logic            timeout;

  // Address range check done on the full byte so that e.g. 0x20 is not
  // aliased onto 0x00 when NUM_REGS is 16.
  assign addr_ok = ({1'b0, rx_data} < 9'(NUM_REGS));

`ifdef CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] tmo_cnt;

  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeout = ((state == GET_ADDR) || (state == GET_DATA)) && !rx_done &&
                   (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Inter-byte cycle counter, cleared by every byte and outside a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (((state != GET_ADDR) && (state != GET_DATA)) || rx_done || timeout) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state, response and register-write decode.
  always_comb begin
    state_next    = state;
    is_write_next = is_write;
    addr_next     = addr;
    tx_data_next  = tx_data;
    tx_start_next = 1'b0;
    err_next      = 1'b0;
    wr_en         = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done) begin
          if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
            is_write_next = (rx_data == CMD_WRITE);
            state_next    = GET_ADDR;
          end else begin
            tx_data_next = RSP_BAD;
            err_next     = 1'b1;
            state_next   = RESP;
          end
        end else begin
          state_next = IDLE;
        end
      end
      GET_ADDR: begin
        if (rx_done) begin
          if (!addr_ok) begin
            tx_data_next = RSP_BAD;
            err_next     = 1'b1;
            state_next   = RESP;
          end else if (is_write) begin
            addr_next  = rx_data[AW-1:0];
            state_next = GET_DATA;
          end else begin
            addr_next    = rx_data[AW-1:0];
            tx_data_next = regs[rx_data[AW-1:0]];
            state_next   = RESP;
          end
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = GET_ADDR;
        end
      end
      GET_DATA: begin
        if (rx_done) begin
          wr_en        = 1'b1;
          tx_data_next = RSP_OK;
          state_next   = RESP;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = GET_DATA;
        end
      end
      RESP: begin
        // Bytes arriving here are dropped on purpose.
        if (!tx_busy) begin
          tx_start_next = 1'b1;
          state_next    = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, frame context and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      is_write <= 1'b0;
      addr     <= '0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      is_write <= is_write_next;
      addr     <= addr_next;
      tx_data  <= tx_data_next;
      tx_start <= tx_start_next;
      err      <= err_next;
    end
  end

  // Register file; the write lands on the data byte's edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (wr_en) begin
      regs[addr] <= rx_data;
    end else begin
      regs <= regs;
    end
  end

  // LED mirror of register 0, one cycle behind the register itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg0_out <= 8'h00;
    end else begin
      reg0_out <= regs[0];
    end
  end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
module tb_uart_reg_ctrl;

  localparam int NREGS = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [7:0] reg0_out;
  logic       err;

  int checks   = 0;
  int failures = 0;

  uart_reg_ctrl #(.NUM_REGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
    .reg0_out(reg0_out), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame level) ----------------
  logic [7:0] m_regs [NREGS];
  logic [7:0] m_frame [$];
  bit         m_pending;
  logic [7:0] m_tx;
  bit         m_start;
  bit         m_err;
  logic [7:0] m_reg0;
  bit         m_valid = 0;

  task automatic m_respond(input logic [7:0] b, input bit bad);
    m_tx      = b;
    m_err     = bad;
    m_pending = 1;
    m_frame.delete();
  endtask

  task automatic model_edge();
    m_start = 0;
    m_err   = 0;
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_frame.delete();
      m_pending = 0;
      m_tx      = 8'h00;
      m_reg0    = 8'h00;
      m_valid   = 1;
    end else begin
      m_reg0 = m_regs[0];
      if (m_pending) begin
        if (!tx_busy) begin
          m_start   = 1;
          m_pending = 0;
        end
      end else if (rx_done) begin
        m_frame.push_back(rx_data);
        if (m_frame.size() == 1) begin
          if (rx_data != 8'h57 && rx_data != 8'h52) m_respond(8'h3F, 1);
        end else if (m_frame.size() == 2) begin
          if (int'(rx_data) >= NREGS) m_respond(8'h3F, 1);
          else if (m_frame[0] == 8'h52) m_respond(m_regs[rx_data], 0);
        end else begin
          m_regs[m_frame[1]] = rx_data;
          m_respond(8'h4B, 0);
        end
      end
    end
  endtask

  always @(posedge clk) model_edge();

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("tx_start", {31'd0, tx_start}, {31'd0, m_start});
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("tx_data", {24'd0, tx_data}, {24'd0, m_tx});
      chk("reg0_out", {24'd0, reg0_out}, {24'd0, m_reg0});
    end
  end

  // Event counters for the directed literal checks.
  int         n_start = 0;
  int         n_err   = 0;
  logic [7:0] last_tx = 8'h00;
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      n_start++;
      last_tx = tx_data;
    end
    if (err === 1'b1) n_err++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    tick();
    rx_done = 1'b1;
    rx_data = b;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic wait_resp(input string name, input int s0);
    int k = 0;
    while (n_start == s0 && k < 2000) begin
      tick();
      k++;
    end
    if (n_start == s0) chk({name, "_resp_timeout"}, 32'd0, 32'd1);
    tick();
  endtask

  task automatic frame_check(input string name, input int s0, input int e0,
                             input int exp_err, input logic [7:0] exp_tx);
    wait_resp(name, s0);
    chk({name, "_starts"}, n_start - s0, 32'd1);
    chk({name, "_errs"}, n_err - e0, exp_err);
    chk({name, "_tx"}, {24'd0, last_tx}, {24'd0, exp_tx});
  endtask

  int s0;
  int e0;

  initial begin
    rst_n   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tx_busy = 1'b0;
    repeat (3) tick();
    chk("rst_tx_data", {24'd0, tx_data}, 32'h0);
    chk("rst_reg0", {24'd0, reg0_out}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Write then read back register 3.
    s0 = n_start; e0 = n_err;
    send(8'h57); send(8'h03); send(8'hA5);
    frame_check("wr3", s0, e0, 0, 8'h4B);
    s0 = n_start; e0 = n_err;
    send(8'h52); send(8'h03);
    frame_check("rd3", s0, e0, 0, 8'hA5);

    // Register 0 mirror and read-after-write.
    s0 = n_start; e0 = n_err;
    send(8'h57); send(8'h00); send(8'h5A);
    frame_check("wr0", s0, e0, 0, 8'h4B);
    chk("reg0_led", {24'd0, reg0_out}, 32'h5A);
    s0 = n_start; e0 = n_err;
    send(8'h52); send(8'h00);
    frame_check("rd0", s0, e0, 0, 8'h5A);

    // Rejections: bad command, out-of-range addresses (0x20 and first past end).
    s0 = n_start; e0 = n_err;
    send(8'h41);
    frame_check("badcmd", s0, e0, 1, 8'h3F);
    s0 = n_start; e0 = n_err;
    send(8'h52); send(8'h20);
    frame_check("badaddr", s0, e0, 1, 8'h3F);
    s0 = n_start; e0 = n_err;
    send(8'h57); send(8'h10);
    frame_check("addr16", s0, e0, 1, 8'h3F);
    s0 = n_start; e0 = n_err;
    send(8'h57); send(8'h0F); send(8'hC3);
    frame_check("wr15", s0, e0, 0, 8'h4B);
    s0 = n_start; e0 = n_err;
    send(8'h52); send(8'h0F);
    frame_check("rd15", s0, e0, 0, 8'hC3);
    s0 = n_start; e0 = n_err;
    send(8'h52); send(8'h03);
    frame_check("rd3_kept", s0, e0, 0, 8'hA5);

    // Transmitter busy for 500 cycles.
    tx_busy = 1'b1;
    s0 = n_start; e0 = n_err;
    send(8'h52); send(8'h03);
    repeat (500) tick();
    chk("busy_no_start", n_start - s0, 32'd0);
    tx_busy = 1'b0;
    frame_check("busy_rd3", s0, e0, 0, 8'hA5);

    // Reset mid-frame abandons the write.
    send(8'h57); send(8'h05);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    s0 = n_start; e0 = n_err;
    send(8'hFF);
    frame_check("post_rst_ff", s0, e0, 1, 8'h3F);
    s0 = n_start; e0 = n_err;
    send(8'h52); send(8'h05);
    frame_check("rd5_zero", s0, e0, 0, 8'h00);

    // A byte coincident with reset is ignored: 0x03 must then be a bad command.
    tick();
    rst_n   = 1'b0;
    rx_done = 1'b1;
    rx_data = 8'h57;
    tick();
    rst_n   = 1'b1;
    rx_done = 1'b0;
    s0 = n_start; e0 = n_err;
    send(8'h03);
    frame_check("rst_coincident", s0, e0, 1, 8'h3F);

    // Randomised traffic, checked every cycle by the model.
    for (int c = 0; c < 6000; c++) begin
      tick();
      rst_n   = ($urandom_range(0, 399) != 0);
      rx_done = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       rx_data = 8'h57;
        1:       rx_data = 8'h52;
        2:       rx_data = 8'($urandom_range(0, 17));
        3:       rx_data = 8'($urandom_range(0, 255));
        default: rx_data = 8'($urandom_range(0, 15));
      endcase
      tx_busy = ($urandom_range(0, 3) == 0);
    end
    tick();
    rst_n   = 1'b1;
    rx_done = 1'b0;
    tx_busy = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_reg_ctrl.md
UART_REG_CTRL -- requirements
Module: uart_reg_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: number of 8-bit registers (power of 2, 2..256).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000: inter-byte timeout in clk cycles (used only with CMD_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART receiver, valid when rx_done=1.
REQ-006 SHALL have port rx_done  input  1  one-cycle strobe: rx_data holds a new byte.
REQ-007 SHALL have port tx_busy  input  1  UART transmitter busy; high = cannot accept a byte.
REQ-008 SHALL have port tx_data  output  8  response byte to the transmitter.
REQ-009 SHALL have port tx_start  output  1  one-cycle strobe: tx_data is to be sent.
REQ-010 SHALL have port reg0_out  output  8  continuous copy of register 0, for LEDs.
REQ-011 SHALL have port err  output  1  one-cycle strobe on any rejected frame.

Function
REQ-012 SHALL hold NUM_REGS x 8-bit registers, addressed by rx_data[log2(NUM_REGS)-1:0].
REQ-013 SHALL accept the write frame 0x57 ('W'), addr, data and the read frame 0x52 ('R'), addr, one byte per rx_done strobe.
REQ-014 SHALL implement the states IDLE, GET_ADDR, GET_DATA and RESP.
REQ-015 In IDLE, on rx_done: 'W' or 'R' -> GET_ADDR with the command latched; any other byte -> RESP with tx_data=0x3F ('?') and an err pulse.
REQ-016 In GET_ADDR, on rx_done: if addr >= NUM_REGS -> RESP with 0x3F and an err pulse; else latch addr, then a write goes to GET_DATA and a read goes to RESP with tx_data=reg[addr].
REQ-017 In GET_DATA, on rx_done: reg[addr] <= rx_data on that same edge, then -> RESP with tx_data=0x4B ('K').
REQ-018 In RESP: while tx_busy=1, hold; on the first cycle with tx_busy=0, pulse tx_start for exactly one cycle with tx_data stable, then -> IDLE.
REQ-019 Response latency: tx_start SHALL assert no earlier than 1 cycle after the final frame byte's rx_done, and on the first cycle tx_busy=0 thereafter.
REQ-020 rx_done arriving while in RESP SHALL be dropped, with no state change and no err.
REQ-021 tx_data SHALL change only on entry to RESP and SHALL otherwise hold its last value.
REQ-022 err SHALL pulse in the same cycle as the state transition into RESP for a rejected frame.
REQ-023 reg0_out SHALL equal reg[0] registered, updating 1 cycle after a write to address 0.
REQ-024 A read of an address written in the preceding frame SHALL return the new value.

Reset
REQ-025 On a clk edge with rst_n=0: state=IDLE, all registers=0x00, tx_data=0x00, tx_start=0, err=0, reg0_out=0x00, timeout counter=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no register write and no tx_start.
REQ-027 rx_done coincident with rst_n=0 SHALL be ignored.

Configuration
REQ-028 With macro CMD_TIMEOUT_EN defined: in GET_ADDR or GET_DATA, a counter SHALL count cycles since the last rx_done.
REQ-029 With CMD_TIMEOUT_EN defined: on reaching TIMEOUT_CYCLES-1 with no rx_done, the block SHALL return to IDLE, pulse err and send no response.
REQ-030 With CMD_TIMEOUT_EN defined: if rx_done and the timeout occur in the same cycle, rx_done SHALL win.
REQ-031 Without CMD_TIMEOUT_EN: no counter SHALL exist, and the block SHALL wait indefinitely in GET_ADDR and GET_DATA.

Verification
REQ-032 Send 0x57,0x03,0xA5 -> reg[3]=0xA5, exactly one tx_start with tx_data=0x4B, err never asserted.
REQ-033 Send 0x57,0x00,0x5A then 0x52,0x00 -> reg0_out=0x5A one cycle after the write; the second response is tx_data=0x5A.
REQ-034 Send 0x41 -> one err pulse and tx_data=0x3F; send 0x52,0x20 -> one err pulse and tx_data=0x3F; registers unchanged.
REQ-035 Hold tx_busy=1 for 500 cycles after 0x52,0x03 -> no tx_start during busy; one tx_start on the first cycle with tx_busy=0.
REQ-036 Send 0x57,0x05, then rst_n=0 for 1 cycle, then 0xFF -> state IDLE, reg[5]=0x00, 0xFF rejected with 0x3F.
REQ-037 With CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100: send 0x57, then idle 100 cycles -> err pulse, no tx_start; then 0x52,0x00 returns 0x00.
